// File: rtl/tl_rx_vc_read_arbiter_pkg.sv
// Shared encodings for the RX virtual-channel read scheduler: traffic classes,
// FSM states and the beat-counter width helper.
package tl_rx_vc_pkg;

   typedef enum logic [1:0] {
      CLS_P   = 2'd0,
      CLS_NP  = 2'd1,
      CLS_CPL = 2'd2
   } vc_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   localparam int NUM_VC = 3;

   // One extra bit so a Length of 0 (1024 DW) still fits as a beat count.
   function automatic int beat_cnt_w(input int length_width);
      return length_width + 1;
   endfunction

endpackage

// File: rtl/tl_rx_vc_read_arbiter_if.sv
// Buffer-status / sink-handshake bundle between the VC buffers, the read
// arbiter (master) and the downstream AXI bridge (slave).
interface tl_rx_vc_read_arbiter_if #(
   parameter int LENGTH_WIDTH = 10
);
   logic [2:0]              i_hdr_empty;
   logic [2:0]              i_data_empty;
   logic [2:0]              i_has_data;
   logic [LENGTH_WIDTH-1:0] i_p_length;
   logic [LENGTH_WIDTH-1:0] i_np_length;
   logic [LENGTH_WIDTH-1:0] i_cpl_length;
   logic                    i_sink_ready;
   logic                    o_valid;
   logic [1:0]              o_sel;
   logic                    o_sop;
   logic                    o_eop;
   logic [2:0]              o_r_hdr_inc;
   logic [2:0]              o_r_data_inc;

   modport master (
      input  i_hdr_empty, i_data_empty, i_has_data,
      input  i_p_length, i_np_length, i_cpl_length, i_sink_ready,
      output o_valid, o_sel, o_sop, o_eop, o_r_hdr_inc, o_r_data_inc
   );

   modport slave (
      output i_hdr_empty, i_data_empty, i_has_data,
      output i_p_length, i_np_length, i_cpl_length, i_sink_ready,
      input  o_valid, o_sel, o_sop, o_eop, o_r_hdr_inc, o_r_data_inc
   );
endinterface

// File: rtl/tl_rx_vc_read_arbiter_prio.sv
// Combinational class select: starved CPL, starved NP, then base order
// P > CPL > NP.
module tl_rx_vc_arb_prio
   import tl_rx_vc_pkg::*;
(
   input  logic [2:0] cand,
   input  logic       promote_np,
   input  logic       promote_cpl,
   output logic [1:0] gnt,
   output logic       gnt_vld
);

   always_comb begin
      gnt     = CLS_P;
      gnt_vld = |cand;
      if (promote_cpl && cand[2])      gnt = CLS_CPL;
      else if (promote_np && cand[1])  gnt = CLS_NP;
      else if (cand[0])                gnt = CLS_P;
      else if (cand[2])                gnt = CLS_CPL;
      else if (cand[1])                gnt = CLS_NP;
   end

endmodule

// File: rtl/tl_rx_vc_read_arbiter.sv
// RX VC read scheduler: grants one class, streams its header and payload beats
// and strobes that class's read pointers. Optional NP/CPL starvation promotion
// is compiled in with TL_RX_VC_ARB_STARVE_EN.
module tl_rx_vc_read_arbiter
   import tl_rx_vc_pkg::*;
#(
   parameter int LENGTH_WIDTH = 10,
   parameter int BEAT_DW      = 8,
   parameter int STARVE_LIMIT = 8
) (
   input logic                    i_clk,
   input logic                    i_n_rst,
   tl_rx_vc_read_arbiter_if.master bus
);

   localparam int CW = beat_cnt_w(LENGTH_WIDTH);
   localparam int SH = $clog2(BEAT_DW);

   if (BEAT_DW < 1 || (BEAT_DW & (BEAT_DW - 1)) != 0) begin : g_bad_beat
      $error("BEAT_DW must be a power of two");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   arb_state_e              state;
   logic [1:0]              sel;
   logic                    has_data_q;
   logic [CW-1:0]           cnt;

   logic [2:0]              cand;
   logic [1:0]              gnt;
   logic                    gnt_vld;
   logic                    promote_np;
   logic                    promote_cpl;
   logic [2:0]              gnt_oh;
   logic [2:0]              sel_oh;
   logic [LENGTH_WIDTH-1:0] gnt_len;
   logic [31:0]             len_dw;
   logic [CW-1:0]           gnt_beats;
   logic                    data_ok;
   logic                    hdr_fire;
   logic                    data_fire;

   assign cand   = ~bus.i_hdr_empty;
   assign gnt_oh = 3'b001 << gnt;
   assign sel_oh = 3'b001 << sel;

   tl_rx_vc_arb_prio u_prio (
      .cand        (cand),
      .promote_np  (promote_np),
      .promote_cpl (promote_cpl),
      .gnt         (gnt),
      .gnt_vld     (gnt_vld)
   );

   always_comb begin
      case (gnt)
         2'd1:    gnt_len = bus.i_np_length;
         2'd2:    gnt_len = bus.i_cpl_length;
         default: gnt_len = bus.i_p_length;
      endcase
      len_dw    = (gnt_len == '0) ? (32'd1 << LENGTH_WIDTH) : 32'(gnt_len);
      gnt_beats = CW'((len_dw + 32'(BEAT_DW) - 32'd1) >> SH);
   end

   assign data_ok   = |(sel_oh & ~bus.i_data_empty);
   assign hdr_fire  = (state == ST_HDR) && bus.i_sink_ready;
   assign data_fire = (state == ST_DATA) && data_ok && bus.i_sink_ready;

   // Strobes are combinational so the pointer advances in the accepting cycle.
   assign bus.o_valid      = (state == ST_HDR) || ((state == ST_DATA) && data_ok);
   assign bus.o_sel        = sel;
   assign bus.o_sop        = (state == ST_HDR);
   assign bus.o_eop        = ((state == ST_HDR) && !has_data_q) ||
                             ((state == ST_DATA) && (cnt == CW'(1)));
   assign bus.o_r_hdr_inc  = hdr_fire  ? sel_oh : 3'b000;
   assign bus.o_r_data_inc = data_fire ? sel_oh : 3'b000;

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         state      <= ST_IDLE;
         sel        <= 2'd0;
         has_data_q <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  sel        <= gnt;
                  has_data_q <= |(gnt_oh & bus.i_has_data);
                  cnt        <= gnt_beats;
                  state      <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (bus.i_sink_ready) state <= has_data_q ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
               if (data_fire) begin
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TL_RX_VC_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [SW-1:0] np_starve;
   logic [SW-1:0] cpl_starve;
   logic          arb;

   assign arb = (state == ST_IDLE) && gnt_vld;

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         np_starve  <= '0;
         cpl_starve <= '0;
      end else if (arb) begin
         if (gnt == CLS_NP)                        np_starve <= '0;
         else if (cand[1] && np_starve != LIMIT)   np_starve <= np_starve + SW'(1);
         if (gnt == CLS_CPL)                       cpl_starve <= '0;
         else if (cand[2] && cpl_starve != LIMIT)  cpl_starve <= cpl_starve + SW'(1);
      end
   end

   assign promote_np  = (np_starve == LIMIT);
   assign promote_cpl = (cpl_starve == LIMIT);
`else
   assign promote_np  = 1'b0;
   assign promote_cpl = 1'b0;
`endif

endmodule

// File: tb/tb_tl_rx_vc_read_arbiter.sv
// Directed bench for tl_rx_vc_read_arbiter: per-cycle vector table plus
// sequences for 1024-DW completion, starvation and mid-packet reset.
module tb_tl_rx_vc_read_arbiter;

   logic i_clk   = 1'b0;
   logic i_n_rst = 1'b0;
   int   nvec    = 0;
   int   nmis    = 0;

   always #5 i_clk = ~i_clk;

   tl_rx_vc_read_arbiter_if #(.LENGTH_WIDTH(10)) bus ();

   tl_rx_vc_read_arbiter #(
      .LENGTH_WIDTH (10),
      .BEAT_DW      (8),
      .STARVE_LIMIT (8)
   ) dut (
      .i_clk   (i_clk),
      .i_n_rst (i_n_rst),
      .bus     (bus)
   );

   typedef struct {
      logic [2:0]  he;
      logic [2:0]  de;
      logic [2:0]  hd;
      logic [9:0]  pl;
      logic [9:0]  nl;
      logic [9:0]  cl;
      logic        rdy;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[24];

   // {valid, sel[1:0], sop, eop, hdr_inc[2:0], data_inc[2:0]}
   function automatic logic [10:0] pk(input logic v, input logic [1:0] s,
                                      input logic sop, input logic eop,
                                      input logic [2:0] h, input logic [2:0] d);
      return {v, s, sop, eop, h, d};
   endfunction

   function automatic vec_t mk(input logic [2:0] he, input logic [2:0] de,
                               input logic [2:0] hd, input logic [9:0] pl,
                               input logic [9:0] nl, input logic [9:0] cl,
                               input logic rdy, input logic [10:0] exp);
      vec_t r;
      r.he = he; r.de = de; r.hd = hd; r.pl = pl; r.nl = nl; r.cl = cl;
      r.rdy = rdy; r.exp = exp;
      return r;
   endfunction

   function automatic logic [10:0] outs();
      return {bus.o_valid, bus.o_sel, bus.o_sop, bus.o_eop,
              bus.o_r_hdr_inc, bus.o_r_data_inc};
   endfunction

   task automatic drive(input vec_t v);
      bus.i_hdr_empty  = v.he;
      bus.i_data_empty = v.de;
      bus.i_has_data   = v.hd;
      bus.i_p_length   = v.pl;
      bus.i_np_length  = v.nl;
      bus.i_cpl_length = v.cl;
      bus.i_sink_ready = v.rdy;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   hcnt, dcnt, eop_at, stray, arbs, first_np;

      // P(16 DW) vs NP read, then NP header, then CPL over NP
      tbl[0]  = mk(3'b111, 3'b111, 3'b000, 10'd0,  10'd0, 10'd0, 1'b1, pk(0, 0, 0, 0, 3'b000, 3'b000));
      tbl[1]  = mk(3'b100, 3'b110, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(0, 0, 0, 0, 3'b000, 3'b000));
      tbl[2]  = mk(3'b100, 3'b110, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(1, 0, 1, 0, 3'b001, 3'b000));
      tbl[3]  = mk(3'b100, 3'b110, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(1, 0, 0, 0, 3'b000, 3'b001));
      tbl[4]  = mk(3'b100, 3'b110, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(1, 0, 0, 1, 3'b000, 3'b001));
      tbl[5]  = mk(3'b101, 3'b111, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(0, 0, 0, 0, 3'b000, 3'b000));
      tbl[6]  = mk(3'b101, 3'b111, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(1, 1, 1, 1, 3'b010, 3'b000));
      tbl[7]  = mk(3'b111, 3'b111, 3'b001, 10'd16, 10'd1, 10'd0, 1'b1, pk(0, 1, 0, 0, 3'b000, 3'b000));
      tbl[8]  = mk(3'b001, 3'b011, 3'b100, 10'd0,  10'd1, 10'd8, 1'b1, pk(0, 1, 0, 0, 3'b000, 3'b000));
      tbl[9]  = mk(3'b001, 3'b011, 3'b100, 10'd0,  10'd1, 10'd8, 1'b1, pk(1, 2, 1, 0, 3'b100, 3'b000));
      tbl[10] = mk(3'b111, 3'b011, 3'b100, 10'd0,  10'd1, 10'd8, 1'b1, pk(1, 2, 0, 1, 3'b000, 3'b100));
      tbl[11] = mk(3'b111, 3'b011, 3'b100, 10'd0,  10'd1, 10'd8, 1'b1, pk(0, 2, 0, 0, 3'b000, 3'b000));
      // P(24 DW, 3 beats) with ready toggling and data-empty bubbles
      tbl[12] = mk(3'b110, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(0, 2, 0, 0, 3'b000, 3'b000));
      tbl[13] = mk(3'b110, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b0, pk(1, 0, 1, 0, 3'b000, 3'b000));
      tbl[14] = mk(3'b110, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(1, 0, 1, 0, 3'b001, 3'b000));
      tbl[15] = mk(3'b110, 3'b111, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(0, 0, 0, 0, 3'b000, 3'b000));
      tbl[16] = mk(3'b111, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b0, pk(1, 0, 0, 0, 3'b000, 3'b000));
      tbl[17] = mk(3'b111, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(1, 0, 0, 0, 3'b000, 3'b001));
      tbl[18] = mk(3'b111, 3'b111, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(0, 0, 0, 0, 3'b000, 3'b000));
      tbl[19] = mk(3'b111, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(1, 0, 0, 0, 3'b000, 3'b001));
      tbl[20] = mk(3'b111, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b0, pk(1, 0, 0, 1, 3'b000, 3'b000));
      tbl[21] = mk(3'b111, 3'b111, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(0, 0, 0, 1, 3'b000, 3'b000));
      tbl[22] = mk(3'b111, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(1, 0, 0, 1, 3'b000, 3'b001));
      tbl[23] = mk(3'b111, 3'b110, 3'b001, 10'd24, 10'd0, 10'd0, 1'b1, pk(0, 0, 0, 0, 3'b000, 3'b000));

      drive(tbl[0]);
      i_n_rst = 1'b0;
      tick();
      tick();
      i_n_rst = 1'b1;

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("row%0d", i), 32'(outs()), 32'(tbl[i].exp));
         tick();
      end

      // CPL with Length 0: 1024 DW = 128 beats
      v = mk(3'b011, 3'b011, 3'b100, 10'd0, 10'd0, 10'd0, 1'b1, 11'd0);
      hcnt = 0; dcnt = 0; eop_at = 0; stray = 0;
      for (int c = 0; c < 140; c++) begin
         drive(v);
         #1;
         if (bus.o_r_hdr_inc == 3'b100) begin
            hcnt++;
            v.he = 3'b111;
         end else if (bus.o_r_hdr_inc != 3'b000) stray++;
         if (bus.o_r_data_inc == 3'b100) begin
            dcnt++;
            if (bus.o_eop) eop_at = dcnt;
         end else if (bus.o_r_data_inc != 3'b000) stray++;
         tick();
      end
      chk("cpl1024_hdr_incs", 32'(hcnt), 32'd1);
      chk("cpl1024_data_incs", 32'(dcnt), 32'd128);
      chk("cpl1024_eop_beat", 32'(eop_at), 32'd128);
      chk("cpl1024_stray_strobes", 32'(stray), 32'd0);

      // P header-only TLPs back to back with an NP waiting
      i_n_rst = 1'b0;
      tick();
      i_n_rst = 1'b1;
      v = mk(3'b100, 3'b111, 3'b000, 10'd1, 10'd1, 10'd0, 1'b1, 11'd0);
      drive(v);
      arbs = 0; first_np = 0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (bus.o_valid && bus.o_sop) begin
            arbs++;
            if (bus.o_sel == 2'd1 && first_np == 0) first_np = arbs;
         end
         tick();
      end
`ifdef TL_RX_VC_ARB_STARVE_EN
      chk("starve_np_grant_arb", 32'(first_np), 32'd9);
`else
      chk("strict_np_never_granted", 32'(first_np), 32'd0);
`endif
      chk("starve_arb_count", 32'(arbs), 32'd15);

      // Reset in the middle of an NP payload
      i_n_rst = 1'b0;
      tick();
      i_n_rst = 1'b1;
      v = mk(3'b101, 3'b101, 3'b010, 10'd0, 10'd16, 10'd0, 1'b1, 11'd0);
      drive(v);
      tick();
      tick();
      chk("rst_pre_data_beat", 32'(outs()), 32'(pk(1, 1, 0, 0, 3'b000, 3'b010)));
      i_n_rst = 1'b0;
      #1;
      chk("rst_outputs_immediate", 32'(outs()), 32'd0);
      tick();
      chk("rst_held_cycle1", 32'(outs()), 32'd0);
      tick();
      chk("rst_held_cycle2", 32'(outs()), 32'd0);
      v.he = 3'b111;
      drive(v);
      i_n_rst = 1'b1;
      tick();
      chk("rst_release_idle", 32'(outs()), 32'd0);
      v = mk(3'b110, 3'b111, 3'b000, 10'd1, 10'd0, 10'd0, 1'b1, 11'd0);
      drive(v);
      #1;
      chk("rst_then_arbitrate_idle", 32'(outs()), 32'd0);
      tick();
      chk("rst_then_hdr", 32'(outs()), 32'(pk(1, 0, 1, 1, 3'b001, 3'b000)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
